// File: rtl/counter_event_fifo.sv
// Logs counter rollover/load events as {type, seq, q} records in a synchronous FIFO.
// Optional COUNTER_EVT_DROPCNT_EN adds a saturating drop_cnt output behind overflow.
module counter_event_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable_,
  input  logic [3:0]    Q_,
  input  logic          rco_,
  input  logic          load_,
  input  logic          rd_en,
  output logic [7:0]    dout,
  output logic          dout_valid,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          overflow
`ifdef COUNTER_EVT_DROPCNT_EN
  ,
  output logic [7:0]    drop_cnt
`endif
);

  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [1:0]    seq;
  logic          evt;
  logic [1:0]    evt_type;
  logic          pop_acc;
  logic          push_acc;
  logic          drop;
  logic [AW:0]   count_nxt;

  // Read handshake: rd_en is a request, accepted on any edge where the FIFO is
  // not empty; the record appears on dout with dout_valid high for exactly the
  // following cycle. Requests while empty are ignored and dout holds.
  always_comb begin
    evt       = enable_ & (rco_ | load_);
    evt_type  = {load_, rco_};
    pop_acc   = rd_en & ~empty;
    push_acc  = evt & (~full | pop_acc);
    drop      = evt & full & ~pop_acc;
    count_nxt = count;
    if (push_acc && !pop_acc)      count_nxt = count + CNT_ONE;
    else if (pop_acc && !push_acc) count_nxt = count - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      seq        <= '0;
      count      <= '0;
      empty      <= 1'b1;
      full       <= 1'b0;
      dout       <= 8'h00;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= pop_acc;
      if (pop_acc) begin
        dout   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push_acc) wr_ptr <= wr_ptr + PTR_ONE;
      // seq advances on drops too, so the consumer sees the gap
      if (evt) seq <= seq + 2'd1;
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == FULL_CNT);
    end
  end

  // At full with a simultaneous pop, wr_ptr == rd_ptr: the old entry is read
  // out on the same edge it is overwritten.
  always_ff @(posedge clk) begin
    if (push_acc && !reset) mem[wr_ptr] <= {evt_type, seq, Q_};
  end

`ifdef COUNTER_EVT_DROPCNT_EN
  always_ff @(posedge clk) begin
    if (reset) drop_cnt <= 8'h00;
    else if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
  end

  assign overflow = (drop_cnt != 8'h00);
`else
  always_ff @(posedge clk) begin
    if (reset)     overflow <= 1'b0;
    else if (drop) overflow <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_counter_event_fifo.sv
// Directed bench for counter_event_fifo (DEPTH=8); honours COUNTER_EVT_DROPCNT_EN.
module tb_counter_event_fifo;

  logic       clk;
  logic       reset;
  logic       enable_;
  logic [3:0] Q_;
  logic       rco_;
  logic       load_;
  logic       rd_en;
  logic [7:0] dout;
  logic       dout_valid;
  logic       empty;
  logic       full;
  logic [3:0] count;
  logic       overflow;
`ifdef COUNTER_EVT_DROPCNT_EN
  logic [7:0] drop_cnt;
`endif

  int passed = 0;
  int total  = 0;
  logic [7:0] exp_q[$];

  counter_event_fifo #(.DEPTH(8), .AW(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable_    (enable_),
    .Q_         (Q_),
    .rco_       (rco_),
    .load_      (load_),
    .rd_en      (rd_en),
    .dout       (dout),
    .dout_valid (dout_valid),
    .empty      (empty),
    .full       (full),
    .count      (count),
    .overflow   (overflow)
`ifdef COUNTER_EVT_DROPCNT_EN
    ,
    .drop_cnt   (drop_cnt)
`endif
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // scoreboard: next popped record must match the head of exp_q
  task automatic chk_pop(input string tag);
    logic [7:0] e;
    e = exp_q.pop_front();
    chk({tag, "_valid"}, 16'(dout_valid), 16'h1);
    chk({tag, "_dout"}, 16'(dout), 16'(e));
  endtask

  initial begin
    reset = 1'b1; enable_ = 1'b1; Q_ = 4'h0; rco_ = 1'b1; load_ = 1'b0; rd_en = 1'b0;

    // 1. reset with an event pending
    tick(); tick();
    chk("rst_count", 16'(count), 16'h0);
    chk("rst_empty", 16'(empty), 16'h1);
    chk("rst_full", 16'(full), 16'h0);
    chk("rst_dout", 16'(dout), 16'h00);
    chk("rst_valid", 16'(dout_valid), 16'h0);
    chk("rst_ovf", 16'(overflow), 16'h0);
    reset = 1'b0; rco_ = 1'b0;

    // 2. single rollover, then one read
    Q_ = 4'hF; rco_ = 1'b1; tick(); rco_ = 1'b0;
    chk("roll_count1", 16'(count), 16'h1);
    chk("roll_empty", 16'(empty), 16'h0);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    chk("roll_count0", 16'(count), 16'h0);
    exp_q.push_back(8'h4F);
    chk_pop("roll");
    tick();
    chk("roll_valid_drop", 16'(dout_valid), 16'h0);
    chk("roll_dout_hold", 16'(dout), 16'h4F);

    // 3. reset to restart seq, then fill with 8 loads
    reset = 1'b1; tick(); reset = 1'b0;
    load_ = 1'b1;
    for (int i = 0; i < 8; i++) begin
      Q_ = 4'(i);
      tick();
    end
    chk("fill_full", 16'(full), 16'h1);
    chk("fill_count", 16'(count), 16'h8);
    chk("fill_ovf", 16'(overflow), 16'h0);

    // 4. push + pop at full: oldest out, new rollover (seq 0, q 5) in
    load_ = 1'b0; rco_ = 1'b1; Q_ = 4'h5; rd_en = 1'b1; tick();
    rd_en = 1'b0; rco_ = 1'b0;
    chk("pp_count", 16'(count), 16'h8);
    chk("pp_full", 16'(full), 16'h1);
    chk("pp_ovf", 16'(overflow), 16'h0);
    exp_q.push_back(8'h80);
    chk_pop("pp");

    // two dropped loads at full
    load_ = 1'b1; Q_ = 4'hA; tick(); tick(); load_ = 1'b0;
    chk("drop_ovf", 16'(overflow), 16'h1);
    chk("drop_count", 16'(count), 16'h8);
`ifdef COUNTER_EVT_DROPCNT_EN
    chk("drop_cnt", 16'(drop_cnt), 16'h2);
`endif

    // drain: remaining loads then the rollover stored at full
    exp_q.push_back(8'h91); exp_q.push_back(8'hA2); exp_q.push_back(8'hB3);
    exp_q.push_back(8'h84); exp_q.push_back(8'h95); exp_q.push_back(8'hA6);
    exp_q.push_back(8'hB7); exp_q.push_back(8'h45);
    rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_pop("drain");
    end
    rd_en = 1'b0;
    chk("drain_count", 16'(count), 16'h0);
    chk("drain_empty", 16'(empty), 16'h1);

    reset = 1'b1; tick(); reset = 1'b0;
    chk("ovf_clear", 16'(overflow), 16'h0);
    chk("ovf_rst_dout", 16'(dout), 16'h00);

    // 5. both events plus read on empty
    rco_ = 1'b1; load_ = 1'b1; Q_ = 4'h3; rd_en = 1'b1; tick();
    rco_ = 1'b0; load_ = 1'b0;
    chk("both_valid", 16'(dout_valid), 16'h0);
    chk("both_dout_hold", 16'(dout), 16'h00);
    chk("both_count", 16'(count), 16'h1);
    tick(); rd_en = 1'b0;
    exp_q.push_back(8'hC3);
    chk_pop("both");
    chk("both_count0", 16'(count), 16'h0);
    tick();
    chk("both_valid_drop", 16'(dout_valid), 16'h0);

    // 6. enable gating
    enable_ = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rco_ = ~rco_; Q_ = 4'(i); tick();
    end
    chk("gate_count", 16'(count), 16'h0);
    chk("gate_empty", 16'(empty), 16'h1);
    enable_ = 1'b1; rco_ = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("fill5_count", 16'(count), 16'h5);
    // reset with an event on the same edge: nothing pushed
    reset = 1'b1; tick(); reset = 1'b0;
    chk("midrst_count", 16'(count), 16'h0);
    chk("midrst_empty", 16'(empty), 16'h1);
    Q_ = 4'h7; tick(); rco_ = 1'b0;
    chk("seq0_count", 16'(count), 16'h1);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    exp_q.push_back(8'h47);
    chk_pop("seq0");

    // push + pop at count=1
    rco_ = 1'b1; Q_ = 4'h2; tick();
    Q_ = 4'h9; rd_en = 1'b1; tick();
    rco_ = 1'b0; rd_en = 1'b0;
    chk("pp1_count", 16'(count), 16'h1);
    exp_q.push_back(8'h52);
    chk_pop("pp1");
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    exp_q.push_back(8'h69);
    chk_pop("pp1_next");
    chk("pp1_empty", 16'(empty), 16'h1);

    // final report
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/counter_event_fifo.md
Name: counter_event_fifo

Overview:
- Downstream consumer of the 4-bit mode counter. Samples the counter's Q_, rco_ and load_ outputs every cycle.
- Each rollover or load event becomes a tagged 8-bit record in a small synchronous FIFO.
- A checker or host drains the records through a rd_en/dout_valid handshake, so counter events are logged without cycle-exact polling.

Parameters:
- DEPTH, 8, number of FIFO entries; power of two, 2..64.
- AW, 3, pointer width; must equal log2(DEPTH).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- enable_  input  1  capture enable; when low, no events are pushed.
- Q_  input  4  counter value, sampled the same cycle as the event.
- rco_  input  1  counter ripple-carry-out (rollover event).
- load_  input  1  counter load indication (load event).
- rd_en  input  1  pop request.
- dout  output  8  popped record {type[1:0], seq[1:0], q[3:0]}.
- dout_valid  output  1  one-cycle strobe; dout holds a new record.
- empty  output  1  FIFO holds 0 entries.
- full  output  1  FIFO holds DEPTH entries.
- count  output  AW+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: an event was dropped because the FIFO was full.

Behaviour:
- Reset (synchronous, sampled at posedge clk while reset=1):
  - wr_ptr, rd_ptr, count, seq are cleared to 0.
  - dout=8'h00, dout_valid=0, overflow=0, empty=1, full=0.
  - Memory contents are don't-care.
  - Reset asserted mid-operation discards all stored entries on that edge; an event on that same edge is not pushed.
- Event detect:
  - evt = enable_ & (rco_ | load_).
  - type = {load_, rco_}: 01 = rollover, 10 = load, 11 = both in the same cycle (one record, not two).
- Push:
  - On evt with !full, or on evt with full and a simultaneous accepted pop, write {type, seq, Q_} at wr_ptr.
  - Then wr_ptr += 1 (wraps mod DEPTH) and seq += 1 (2-bit, wraps 3 -> 0).
- Drop:
  - On evt with full and no accepted pop, nothing is written and overflow is set to 1.
  - seq still increments, so the checker sees a gap.
  - overflow clears only on reset.
- Pop:
  - Accepted when rd_en & !empty.
  - dout is loaded with mem[rd_ptr] and rd_ptr += 1 (wraps).
  - dout_valid = 1 on the cycle after the accepting edge; it is 0 otherwise.
- rd_en on empty:
  - Ignored; dout holds its previous value and dout_valid = 0.
  - A simultaneous push is still accepted.
- Push and pop on the same edge:
  - count unchanged, both pointers advance.
  - Legal at full (the freed slot is reused) and at count=1.
- Occupancy:
  - count += push_accepted - pop_accepted.
  - empty = (count==0), full = (count==DEPTH); both registered-consistent with count.
- Latency:
  - An event at edge N is visible in count after edge N.
  - Earliest pop accepted at edge N+1; dout_valid at cycle N+2.
- enable_ low gates pushes only; pops continue.

Optional Feature:
- Macro: COUNTER_EVT_DROPCNT_EN.
- Defined:
  - Adds output drop_cnt [7:0], cleared on reset.
  - Increments on each dropped event and saturates at 8'hFF.
  - overflow = (drop_cnt != 0).
- Undefined:
  - No drop_cnt port; overflow is the 1-bit sticky flag only.
  - Push/pop behaviour is identical in both builds.

Test Plan:
1. Reset: hold reset=1 for 2 cycles with rco_=1, enable_=1 -> count=0, empty=1, full=0, dout=00, dout_valid=0, overflow=0.
2. Single rollover: Q_=4'hF, rco_=1 for 1 cycle; rd_en pulsed the next cycle -> count goes 1 then 0; dout=8'b01_00_1111 (8'h4F) with dout_valid=1 for exactly one cycle.
3. Fill/overflow: DEPTH=8, 10 consecutive load_ events with no reads -> full=1 after the 8th; events 9-10 dropped; overflow=1; with COUNTER_EVT_DROPCNT_EN, drop_cnt=2. Draining 8 entries gives seq 0,1,2,3,0,1,2,3.
4. Simultaneous push and pop at full: rco_=1 and rd_en=1 on the same edge -> count stays 8, no overflow, oldest record popped, new record stored.
5. Both events plus read on empty: rco_=1, load_=1, Q_=4'h3 with rd_en=1 while empty -> pop ignored (dout_valid=0); one record type=11 stored; next read gives dout=8'hC3.
6. Enable gating and mid-run reset: enable_=0 with rco_ toggling -> count unchanged. Then fill 5 entries and assert reset for 1 cycle -> count=0, seq restarts at 0 on the next event.
